// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the two-port data-RAM arbiter.
//   ARB_M0 / ARB_M1 : master index constants (m0 = core LSU, m1 = JTAG debug)
//   BE_W            : byte-enable width (four byte lanes)
//   arb_rsp_t       : response pipeline register (valid, owner, err, rd)
package ram_arb_pkg;

    localparam int unsigned BE_W = 4;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    typedef struct packed {
        logic valid;  // a response is due this cycle
        logic owner;  // ARB_M0 or ARB_M1
        logic err;    // access was out of range
        logic rd;     // access was a read (rdata comes from the RAM)
    } arb_rsp_t;

endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: two-request grant picker.
//   Default build: fixed priority, request 1 (debug) beats request 0.
//   With RAM_ARB_ROUND_ROBIN_EN defined: on a conflict the port that was not
//   granted most recently wins; a 1-bit pointer holds the last granted index
//   and resets to 0, so request 1 wins the first conflict.
// Ports:
//   clk, rstn        : clock / async active-low reset (round-robin build only)
//   i_req0, i_req1   : requests
//   o_gnt0, o_gnt1   : one-hot (or zero) grants, combinational from requests
module arb_pick2 (
`ifdef RAM_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rstn,
`endif
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);
    import ram_arb_pkg::*;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic r_last;
    logic w_m1_wins;

    // m1 wins a conflict only when m0 was the most recent grantee.
    assign w_m1_wins = (r_last == ARB_M0);
    assign o_gnt1    = i_req1 & (~i_req0 | w_m1_wins);
    assign o_gnt0    = i_req0 & ~o_gnt1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last <= ARB_M0;
        end else if (o_gnt0 | o_gnt1) begin
            r_last <= o_gnt1 ? ARB_M1 : ARB_M0;
        end
    end
`else
    assign o_gnt1 = i_req1;
    assign o_gnt0 = i_req0 & ~i_req1;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the word-addressed data RAM between the core load/store
// port (m0) and the JTAG debug port (m1). One access per cycle, one-cycle
// response latency, response routed back to the owning requester.
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN (round-robin on conflicts;
// default is fixed priority m1 > m0).
// Ports:
//   clk, rstn                     : clock, async active-low reset
//   mX_req/we/addr/wdata/be       : request side of master X (held until gnt)
//   mX_gnt                        : request accepted this cycle
//   mX_rvalid/rdata/err           : response pulse one cycle after grant
//   ram_en/we/addr/wdata          : RAM port strobe, lane enables, word addr
//   ram_rdata                     : RAM read data, one cycle after ram_en
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DEPTH     = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned AW        = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [31:0]     m0_addr,
    input  logic [31:0]     m0_wdata,
    input  logic [BE_W-1:0] m0_be,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [31:0]     m1_addr,
    input  logic [31:0]     m1_wdata,
    input  logic [BE_W-1:0] m1_be,
    output logic            m0_gnt,
    output logic            m1_gnt,
    output logic            m0_rvalid,
    output logic            m1_rvalid,
    output logic [31:0]     m0_rdata,
    output logic [31:0]     m1_rdata,
    output logic            m0_err,
    output logic            m1_err,
    output logic            ram_en,
    output logic [BE_W-1:0] ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [31:0]     ram_wdata,
    input  logic [31:0]     ram_rdata
);

    // 33-bit so a full 4 GiB window cannot overflow the bound.
    localparam logic [32:0] RANGE_BYTES = 33'(DEPTH) * 33'd4;

    logic            w_pick0;
    logic            w_pick1;
    logic            w_gnt_any;
    logic            w_we;
    logic [31:0]     w_addr;
    logic [31:0]     w_wdata;
    logic [BE_W-1:0] w_be;
    logic [31:0]     w_off;
    logic            w_in_range;
    logic [31:0]     w_rdata;
    arb_rsp_t        w_rsp_d;
    arb_rsp_t        r_rsp;

    arb_pick2 u_pick (
`ifdef RAM_ARB_ROUND_ROBIN_EN
        .clk    (clk),
        .rstn   (rstn),
`endif
        .i_req0 (m0_req),
        .i_req1 (m1_req),
        .o_gnt0 (w_pick0),
        .o_gnt1 (w_pick1)
    );

    // Grants are combinational; gating with rstn keeps the RAM idle in reset.
    assign m0_gnt    = w_pick0 & rstn;
    assign m1_gnt    = w_pick1 & rstn;
    assign w_gnt_any = m0_gnt | m1_gnt;

    assign w_we    = m1_gnt ? m1_we    : m0_we;
    assign w_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign w_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign w_be    = m1_gnt ? m1_be    : m0_be;

    // Unsigned wrap makes addresses below BASE_ADDR fall out of range too.
    assign w_off      = w_addr - BASE_ADDR;
    assign w_in_range = ({1'b0, w_off} < RANGE_BYTES);

    assign ram_en    = w_gnt_any & w_in_range;
    assign ram_we    = (ram_en & w_we) ? w_be : '0;
    assign ram_addr  = w_off[AW+1:2];
    assign ram_wdata = w_wdata;

    always_comb begin
        w_rsp_d       = '0;
        w_rsp_d.valid = w_gnt_any;
        w_rsp_d.owner = m1_gnt ? ARB_M1 : ARB_M0;
        w_rsp_d.err   = w_gnt_any & ~w_in_range;
        w_rsp_d.rd    = w_gnt_any & ~w_we;
    end

    // Asynchronous reset drops any in-flight response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp <= '0;
        end else begin
            r_rsp <= w_rsp_d;
        end
    end

    assign w_rdata   = (r_rsp.valid & r_rsp.rd & ~r_rsp.err) ? ram_rdata : '0;
    assign m0_rvalid = r_rsp.valid & (r_rsp.owner == ARB_M0);
    assign m1_rvalid = r_rsp.valid & (r_rsp.owner == ARB_M1);
    assign m0_rdata  = m0_rvalid ? w_rdata : '0;
    assign m1_rdata  = m1_rvalid ? w_rdata : '0;
    assign m0_err    = m0_rvalid & r_rsp.err;
    assign m1_err    = m1_rvalid & r_rsp.err;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors for ram_arbiter with a bench-side RAM, a
// transaction-level reference model, a per-cycle compare process and a few
// hand-computed literal expectations.
module tb_ram_arbiter;

    localparam int unsigned DEPTH = 2048;
    localparam int unsigned AW    = 11;

    logic        clk;
    logic        rstn;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    ram_arbiter #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_be     (m0_be),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_be     (m1_be),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_rdata  (m1_rdata),
        .m0_err    (m0_err),
        .m1_err    (m1_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench RAM: read-before-write, data one cycle after the strobe.
    logic [31:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram_mem[ram_addr];
            for (int i = 0; i < 4; i++) begin
                if (ram_we[i]) ram_mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    bit          started = 0;
    int          last_gnt = 0;
    bit          exp_g0, exp_g1, exp_en;
    logic [3:0]  exp_we;
    logic [31:0] exp_addr, exp_wdata;
    bit          pend_v, pend_own, pend_err;
    logic [31:0] pend_data;
    bit          cur_v, cur_own, cur_err;
    logic [31:0] cur_data;

    task automatic cyc(input logic rn,
                       input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic [3:0] b0,
                       input logic r1, input logic w1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic [3:0] b1);
        bit          m1_wins, w, inr;
        logic [31:0] a, d, off;
        logic [3:0]  b;
        int unsigned idx;
        @(posedge clk);
        #1;
        rstn = rn;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_be = b0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_be = b1;
        // Response scheduled last cycle becomes visible now.
        cur_v = pend_v; cur_own = pend_own; cur_err = pend_err; cur_data = pend_data;
        exp_g0 = 0; exp_g1 = 0; exp_en = 0; exp_we = 4'h0;
        pend_v = 0; pend_own = 0; pend_err = 0; pend_data = 32'h0;
        if (!rn) begin
            cur_v = 0; cur_own = 0; cur_err = 0; cur_data = 32'h0;
            last_gnt = 0;
        end else begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            m1_wins = (last_gnt == 0);
`else
            m1_wins = 1;
`endif
            exp_g1 = r1 && (!r0 || m1_wins);
            exp_g0 = r0 && !exp_g1;
            if (exp_g0 || exp_g1) begin
                last_gnt = exp_g1 ? 1 : 0;
                w   = exp_g1 ? w1 : w0;
                a   = exp_g1 ? a1 : a0;
                d   = exp_g1 ? d1 : d0;
                b   = exp_g1 ? b1 : b0;
                off = a;
                inr = (off < DEPTH * 4);
                idx = (off >> 2) % DEPTH;
                exp_en    = inr;
                exp_we    = (inr && w) ? b : 4'h0;
                exp_addr  = idx;
                exp_wdata = d;
                pend_v    = 1;
                pend_own  = exp_g1;
                pend_err  = !inr;
                pend_data = (inr && !w) ? ref_mem[idx] : 32'h0;
                if (inr && w) begin
                    for (int i = 0; i < 4; i++) begin
                        if (b[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
                    end
                end
            end
        end
        started = 1;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask
    task automatic m0op(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b);
        cyc(1, 1, w, a, d, b, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask
    task automatic m1op(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b);
        cyc(1, 0, 0, 32'h0, 32'h0, 4'h0, 1, w, a, d, b);
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("m0_gnt", 32'(m0_gnt), 32'(exp_g0));
            chk("m1_gnt", 32'(m1_gnt), 32'(exp_g1));
            chk("ram_en", 32'(ram_en), 32'(exp_en));
            chk("ram_we", 32'(ram_we), 32'(exp_we));
            if (exp_en) begin
                chk("ram_addr", 32'(ram_addr), exp_addr);
                chk("ram_wdata", ram_wdata, exp_wdata);
            end
            chk("m0_rvalid", 32'(m0_rvalid), 32'(cur_v && !cur_own));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(cur_v && cur_own));
            if (cur_v && !cur_own) begin
                chk("m0_rdata", m0_rdata, cur_data);
                chk("m0_err", 32'(m0_err), 32'(cur_err));
            end
            if (cur_v && cur_own) begin
                chk("m1_rdata", m1_rdata, cur_data);
                chk("m1_err", 32'(m1_err), 32'(cur_err));
            end
            if (!rstn) begin
                chk("rst_m0_rdata", m0_rdata, 32'h0);
                chk("rst_m1_rdata", m1_rdata, 32'h0);
                chk("rst_err", 32'({m0_err, m1_err}), 32'h0);
            end
        end
    end

    int g0cnt;

    initial begin
        rstn = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;

        // Reset, including requests asserted while reset is held.
        cyc(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        cyc(0, 1, 1, 32'h10, 32'h1, 4'hF, 1, 0, 32'h20, 32'h0, 4'h0);
        #2 chk("lit_rst_gnt", 32'({m0_gnt, m1_gnt}), 32'h0);
        chk("lit_rst_ram_en", 32'(ram_en), 32'h0);

        // m0 full write then read of 0x10.
        m0op(1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        #2 chk("lit_wr_ram_we", 32'(ram_we), 32'hF);
        chk("lit_wr_ram_addr", 32'(ram_addr), 32'h4);
        m0op(0, 32'h10, 32'h0, 4'h0);
        #2 chk("lit_rd_ram_we", 32'(ram_we), 32'h0);
        idle();
        #2 chk("lit_rd_rvalid", 32'(m0_rvalid), 32'h1);
        chk("lit_rd_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("lit_rd_err", 32'(m0_err), 32'h0);

        // m1 partial-lane write.
        m1op(1, 32'h20, 32'h1122_3344, 4'hF);
        m1op(1, 32'h20, 32'h0000_AA00, 4'b0010);
        m1op(0, 32'h20, 32'h0, 4'h0);
        idle();
        #2 chk("lit_lane_rdata", m1_rdata, 32'h1122_AA44);

        // be = 0 write: strobe without lane enables, word unchanged.
        m0op(1, 32'h10, 32'hFFFF_FFFF, 4'h0);
        #2 chk("lit_be0_ram_en", 32'(ram_en), 32'h1);
        m0op(0, 32'h10, 32'h0, 4'h0);
        idle();
        #2 chk("lit_be0_rdata", m0_rdata, 32'hDEAD_BEEF);

        // Out of range: address wrap and exactly DEPTH*4.
        m1op(1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF);
        #2 chk("lit_oor_wr_en", 32'(ram_en), 32'h0);
        m0op(0, 32'h2000, 32'h0, 4'h0);
        #2 chk("lit_oor_rd_gnt", 32'(m0_gnt), 32'h1);
        chk("lit_oor_wr_err", 32'(m1_err), 32'h1);
        idle();
        #2 chk("lit_oor_rd_err", 32'(m0_err), 32'h1);
        chk("lit_oor_rd_rdata", m0_rdata, 32'h0);

        // Conflict: both request reads for four cycles (last grant was m0).
        g0cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 32'h10, 32'h0, 4'h0, 1, 0, 32'h20, 32'h0, 4'h0);
            #2 if (m0_gnt) g0cnt++;
        end
`ifdef RAM_ARB_ROUND_ROBIN_EN
        chk("lit_conflict_m0_gnts", 32'(g0cnt), 32'd2);
`else
        chk("lit_conflict_m0_gnts", 32'(g0cnt), 32'd0);
`endif
        m0op(0, 32'h10, 32'h0, 4'h0);
        idle();

        // Back-to-back reads to different owners.
        m0op(1, 32'h0, 32'hA5A5_0000, 4'hF);
        m0op(1, 32'h4, 32'h0000_5A5A, 4'hF);
        m0op(0, 32'h0, 32'h0, 4'h0);
        m1op(0, 32'h4, 32'h0, 4'h0);
        #2 chk("lit_b2b_m0_rdata", m0_rdata, 32'hA5A5_0000);
        idle();
        #2 chk("lit_b2b_m1_rdata", m1_rdata, 32'h0000_5A5A);
        chk("lit_b2b_m0_quiet", 32'(m0_rvalid), 32'h0);
        idle();

        // Reset right after a granted read drops the response.
        m0op(0, 32'h10, 32'h0, 4'h0);
        cyc(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        #2 chk("lit_rst_drop", 32'({m0_rvalid, m1_rvalid}), 32'h0);
        idle();
        #2 chk("lit_rst_after", 32'({m0_rvalid, m1_rvalid}), 32'h0);
        idle();

        @(posedge clk);
        #1;
        started = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
